// File: rtl/draw_star_box.sv
// Outlines a star's bounding box by writing its one-pixel perimeter into the
// 160x120 VGA framebuffer, one pixel per cycle: top row, bottom row, left column, right column.
module draw_star_box #(
  parameter int xSz    = 8,
  parameter int ySz    = 7,
  parameter int addrSz = 15,
  parameter int colSz  = 3,
  parameter int X_RES  = 160,
  parameter int Y_RES  = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [xSz-1:0]    left,
  input  logic [xSz-1:0]    right,
  input  logic [ySz-1:0]    top,
  input  logic [ySz-1:0]    bottom,
  input  logic [colSz-1:0]  colour,
  output logic [xSz-1:0]    x,
  output logic [ySz-1:0]    y,
  output logic [addrSz-1:0] wrAddr,
  output logic [colSz-1:0]  colourOut,
  output logic              plot,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, TOP, BOTTOM, LEFT, RIGHT, DONE} stateT;

  stateT          state;
  logic [xSz-1:0] lReg, rReg;
  logic [ySz-1:0] tReg, bReg;
  logic [xSz-1:0] rClamp;
  logic [ySz-1:0] bClamp;

  // Keep every write on screen; later states rely on R/B never exceeding the screen edge.
  assign rClamp = (right  > xSz'(X_RES - 1)) ? xSz'(X_RES - 1) : right;
  assign bClamp = (bottom > ySz'(Y_RES - 1)) ? ySz'(Y_RES - 1) : bottom;

  // y*160 + x as two shifts; the 16-bit sum is truncated to the framebuffer width.
  assign wrAddr = addrSz'(16'({y, 7'b0}) + 16'({y, 5'b0}) + 16'(x));

  // NOTE: all state and outputs here use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      colourOut <= '0;
      lReg      <= '0;
      rReg      <= '0;
      tReg      <= '0;
      bReg      <= '0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lReg      <= left;
            rReg      <= rClamp;
            tReg      <= top;
            bReg      <= bClamp;
            colourOut <= colour;
            busy      <= 1'b1;
            if (left > rClamp || top > bClamp) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= TOP;
              x     <= left;
              y     <= top;
              plot  <= 1'b1;
            end
          end
        end
        TOP: begin
          if (x < rReg) begin
            x <= x + xSz'(1);
          end else if (bReg == tReg) begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= BOTTOM;
            x     <= lReg;
            y     <= bReg;
          end
        end
        BOTTOM: begin
          if (x < rReg) begin
            x <= x + xSz'(1);
          end else if (bReg - tReg >= ySz'(2)) begin
            state <= LEFT;
            x     <= lReg;
            y     <= tReg + ySz'(1);
          end else begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end
        end
        LEFT: begin
          // Corners belong to the rows, so the columns cover only T+1..B-1.
          if (y < bReg - ySz'(1)) begin
            y <= y + ySz'(1);
          end else if (rReg != lReg) begin
            state <= RIGHT;
            x     <= rReg;
            y     <= tReg + ySz'(1);
          end else begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end
        end
        RIGHT: begin
          if (y < bReg - ySz'(1)) begin
            y <= y + ySz'(1);
          end else begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_star_box.sv
// Scoreboard bench for draw_star_box: expected pixel writes are queued before each
// start, and a monitor pops and compares one entry for every cycle plot is high.
module tb_draw_star_box;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] left, right;
  logic [6:0] top, bottom;
  logic [2:0] colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [14:0] wrAddr;
  logic [2:0] colourOut;
  logic       plot, busy, done;

  draw_star_box dut (
    .clk(clk), .reset(reset), .start(start),
    .left(left), .right(right), .top(top), .bottom(bottom), .colour(colour),
    .x(x), .y(y), .wrAddr(wrAddr), .colourOut(colourOut),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px;
    int py;
    int addr;
    int col;
    int off;
  } pixT;

  pixT sb[$];
  int  nChecks  = 0;
  int  nFail    = 0;
  int  cycleCnt = 0;
  int  startCyc = 0;
  int  nextOff  = 1;

  always @(posedge clk) cycleCnt++;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard, including its cycle offset.
  initial begin
    pixT e;
    forever begin
      @(negedge clk);
      if (plot) begin
        check("x_on_screen", int'(x <= 8'd159), 1);
        check("y_on_screen", int'(y <= 7'd119), 1);
        if (sb.size() == 0) begin
          check("plot_expected", 0, 1);
        end else begin
          e = sb.pop_front();
          check("plot_x",      int'(x),         e.px);
          check("plot_y",      int'(y),         e.py);
          check("plot_addr",   int'(wrAddr),    e.addr);
          check("plot_colour", int'(colourOut), e.col);
          check("plot_cycle",  cycleCnt - startCyc, e.off);
        end
      end
    end
  end

  task automatic pushPix(input int px, input int py, input int col);
    pixT e;
    e.px   = px;
    e.py   = py;
    e.addr = py * 160 + px;
    e.col  = col;
    e.off  = nextOff;
    sb.push_back(e);
    nextOff++;
  endtask

  task automatic pushRow(input int x0, input int x1, input int py, input int col);
    for (int i = x0; i <= x1; i++) pushPix(i, py, col);
  endtask

  task automatic pushCol(input int px, input int y0, input int y1, input int col);
    for (int i = y0; i <= y1; i++) pushPix(px, i, col);
  endtask

  task automatic applyStart(input int l, input int r, input int t, input int b, input int col);
    left   = 8'(l);
    right  = 8'(r);
    top    = 7'(t);
    bottom = 7'(b);
    colour = 3'(col);
    start  = 1'b1;
  endtask

  // Issue one box and wait (bounded) for done; interruptAt>0 pulses a competing start then.
  task automatic runBox(input string tag, input int l, input int r, input int t, input int b,
                        input int col, input int expDone, input int interruptAt);
    int cyc;
    @(negedge clk);
    applyStart(l, r, t, b, col);
    startCyc = cycleCnt;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (cyc == interruptAt) applyStart(0, 50, 0, 50, ~col);
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, done ? cyc : -1, expDone);
    check({tag, "_busy_in_done"}, int'(busy), 1);
    check({tag, "_plot_in_done"}, int'(plot), 0);
    // A start landing in the DONE cycle must not launch a new box.
    applyStart(1, 4, 1, 4, 7);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse_width"}, int'(done), 0);
    check({tag, "_idle_busy"}, int'(busy), 0);
    check({tag, "_start_in_done_ignored"}, int'(plot), 0);
    check({tag, "_all_writes_seen"}, sb.size(), 0);
    sb.delete();
    nextOff = 1;
  endtask

  initial begin
    reset = 1'b1;
    applyStart(0, 0, 0, 0, 0);
    start = 1'b0;
    #12;
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_addr", int'(wrAddr), 0);
    check("rst_colour", int'(colourOut), 0);
    @(negedge clk);
    reset = 1'b0;

    // 4x3 box: top row, bottom row, then one pixel of each column.
    pushRow(10, 13, 20, 4); pushRow(10, 13, 22, 4); pushPix(10, 21, 4); pushPix(13, 21, 4);
    runBox("box4x3", 10, 13, 20, 22, 4, 11, 0);

    pushPix(5, 7, 2);
    runBox("single", 5, 5, 7, 7, 2, 2, 0);

    // One-pixel-wide column: the right column must be skipped.
    pushPix(3, 0, 1); pushPix(3, 3, 1); pushPix(3, 1, 1); pushPix(3, 2, 1);
    runBox("column", 3, 3, 0, 3, 1, 5, 0);

    pushRow(0, 2, 0, 6);
    runBox("row", 0, 2, 0, 0, 6, 4, 0);

    // Right/bottom beyond the screen clamp to 159/119.
    pushRow(150, 159, 115, 5); pushRow(150, 159, 119, 5);
    pushCol(150, 116, 118, 5); pushCol(159, 116, 118, 5);
    runBox("clamp", 150, 200, 115, 127, 5, 27, 0);

    runBox("inv_lr", 20, 10, 0, 5, 3, 1, 0);
    runBox("inv_tb", 0, 5, 9, 3, 3, 1, 0);

    pushRow(10, 13, 20, 4); pushRow(10, 13, 22, 4); pushPix(10, 21, 4); pushPix(13, 21, 4);
    runBox("busy_start", 10, 13, 20, 22, 4, 11, 3);

    // Asynchronous reset in the middle of a draw.
    @(negedge clk);
    applyStart(10, 13, 20, 22, 4);
    startCyc = cycleCnt;
    pushRow(10, 13, 20, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 reset = 1'b1;
    #1;
    check("midrst_plot", int'(plot), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_writes_before", sb.size(), 0);
    sb.delete();
    nextOff = 1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_x", int'(x), 0);
    check("midrst_y", int'(y), 0);
    check("midrst_colour", int'(colourOut), 0);

    pushRow(10, 13, 20, 4); pushRow(10, 13, 22, 4); pushPix(10, 21, 4); pushPix(13, 21, 4);
    runBox("after_rst", 10, 13, 20, 22, 4, 11, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
